// File: rtl/shared_timer_arbiter_pkg.sv
// Shared definitions for the timer arbiter and its sibling timer blocks:
// FSM state encodings, the default tick divider and the round-robin
// pointer helper.
package shared_timer_arbiter_pkg;

    // FSM encodings shared by the timer blocks
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // One second at 50 MHz
    localparam int TICK_DIV_DEFAULT = 50000000;

    // Round-robin successor of a requester index, wrapping modulo n
    function automatic logic [2:0] next_ptr(input logic [2:0] id, input int n);
        if (int'(id) + 1 >= n) begin
            return 3'd0;
        end
        return id + 3'd1;
    endfunction

endpackage

// File: rtl/shared_timer_arbiter_tick_prescaler.sv
// Tick prescaler: counts 0..TICK_DIV-1 while enabled and flags the terminal
// count so the owner of the timer can step its tick counter.
module tick_prescaler #(
    parameter int CW       = 26,
    parameter int TICK_DIV = 50000000
) (
    input  logic clock,
    input  logic reset_l,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == TERM);

    // Next count: clear wins, otherwise count up and wrap at terminal count
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    // Count register
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/shared_timer_arbiter.sv
// Shared one-shot interval timer with round-robin arbitration among N
// requesters. The winner gets a pulse of dur*TICK_DIV clocks on `out`,
// followed by a one-cycle done strobe.
// Optional feature macro: TIMER_ARB_PRIORITY_EN -- requester 0 becomes
// absolute priority and its grants leave the round-robin pointer untouched.
module shared_timer_arbiter
    import shared_timer_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int DW       = 4,
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int CW       = 26
) (
    input  logic            clock,
    input  logic            reset_l,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] dur,
    output logic [N-1:0]    grant,
    output logic [2:0]      grant_id,
    output logic            busy,
    output logic            out,
    output logic [N-1:0]    done
);

    state_e        state_q;
    logic [N-1:0]  grant_q;
    logic [2:0]    grant_id_q;
    logic          busy_q;
    logic          out_q;
    logic [N-1:0]  done_q;
    logic [2:0]    rr_ptr_q;
    logic [2:0]    rr_ptr_d;
    logic [DW-1:0] remain_q;

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] req_sh;
    logic [N-1:0]   req_rot;
    logic [2:0]     rot_idx;
    logic           rot_hit;
    logic [3:0]     rot_sum;
    logic [2:0]     win_id_d;
    logic           win_vld_d;
    logic [DW-1:0]  dur_sel;
    logic           owner_req;
    logic           tick;

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
    assign out      = out_q;
    assign done     = done_q;

    assign owner_req = |(req & grant_q);

    tick_prescaler #(
        .CW       (CW),
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock   (clock),
        .reset_l (reset_l),
        .clr     (state_q == ST_LOAD),
        .en      (state_q == ST_RUN),
        .tick    (tick)
    );

    // Arbiter: rotate requests by rr_ptr, take the lowest set bit, rotate back
    always_comb begin
        req_dbl = {req, req};
        req_sh  = req_dbl >> rr_ptr_q;
        req_rot = req_sh[N-1:0];
        rot_hit = 1'b0;
        rot_idx = 3'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_hit = 1'b1;
                rot_idx = 3'(i);
            end
        end
        rot_sum = 4'(rr_ptr_q) + 4'(rot_idx);
        if (rot_sum >= 4'(N)) begin
            rot_sum = rot_sum - 4'(N);
        end
        win_id_d  = rot_sum[2:0];
        win_vld_d = rot_hit;
`ifdef TIMER_ARB_PRIORITY_EN
        if (req[0]) begin
            win_id_d  = 3'd0;
            win_vld_d = 1'b1;
        end
`endif
    end

    // Duration of the current owner, muxed with constant slices
    always_comb begin
        dur_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_id_q == 3'(i)) begin
                dur_sel = dur[i*DW +: DW];
            end
        end
    end

    // Pointer value to adopt when the owner releases the timer
    always_comb begin
        rr_ptr_d = next_ptr(grant_id_q, N);
`ifdef TIMER_ARB_PRIORITY_EN
        if (grant_id_q == 3'd0) begin
            rr_ptr_d = rr_ptr_q;
        end
`endif
    end

    // Timer FSM with registered outputs: IDLE -> LOAD -> RUN -> DONE -> IDLE
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            grant_id_q <= 3'd0;
            busy_q     <= 1'b0;
            out_q      <= 1'b0;
            done_q     <= '0;
            rr_ptr_q   <= 3'd0;
            remain_q   <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (win_vld_d) begin
                        grant_q    <= {{(N-1){1'b0}}, 1'b1} << win_id_d;
                        grant_id_q <= win_id_d;
                        busy_q     <= 1'b1;
                        state_q    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    remain_q <= dur_sel;
                    if (!owner_req) begin
                        state_q  <= ST_IDLE;
                        grant_q  <= '0;
                        busy_q   <= 1'b0;
                        rr_ptr_q <= rr_ptr_d;
                    end else if (dur_sel == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= grant_q;
                    end else begin
                        state_q <= ST_RUN;
                        out_q   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!owner_req) begin
                        state_q  <= ST_IDLE;
                        grant_q  <= '0;
                        busy_q   <= 1'b0;
                        out_q    <= 1'b0;
                        rr_ptr_q <= rr_ptr_d;
                    end else if (tick) begin
                        remain_q <= remain_q - DW'(1);
                        if (remain_q == DW'(1)) begin
                            state_q <= ST_DONE;
                            out_q   <= 1'b0;
                            done_q  <= grant_q;
                        end
                    end
                end
                ST_DONE: begin
                    state_q  <= ST_IDLE;
                    grant_q  <= '0;
                    busy_q   <= 1'b0;
                    out_q    <= 1'b0;
                    rr_ptr_q <= rr_ptr_d;
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    out_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_timer_arbiter.sv
// Bench for shared_timer_arbiter (N=4, DW=4, TICK_DIV=4): a timeline model
// predicts every output each cycle, and directed scenarios pin literal values.
module tb_shared_timer_arbiter;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int TD = 4;

    logic          clock;
    logic          reset_l;
    logic [N-1:0]  req;
    logic [N*DW-1:0] dur;
    logic [N-1:0]  grant;
    logic [2:0]    grant_id;
    logic          busy;
    logic          out;
    logic [N-1:0]  done;

    int checks = 0;
    int errors = 0;

    shared_timer_arbiter #(.N(N), .DW(DW), .TICK_DIV(TD), .CW(3)) dut (
        .clock    (clock),
        .reset_l  (reset_l),
        .req      (req),
        .dur      (dur),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .out      (out),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: m_age counts cycles since the grant became visible.
    // Age 0 is the load cycle, ages 1..m_len carry the pulse, age m_len+1 strobes done.
    int m_busy, m_id, m_age, m_len, m_ptr, m_pick;
    bit m_fin;
    always @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            m_busy = 0; m_id = 0; m_age = 0; m_len = 0; m_ptr = 0;
        end else if (m_busy == 0) begin
            m_pick = -1;
`ifdef TIMER_ARB_PRIORITY_EN
            if (req[0]) m_pick = 0;
`endif
            for (int k = 0; k < N; k++)
                if (m_pick < 0 && req[(m_ptr + k) % N]) m_pick = (m_ptr + k) % N;
            if (m_pick >= 0) begin
                m_busy = 1; m_id = m_pick; m_age = 0;
            end
        end else begin
            m_fin = 0;
            if (m_age == 0) begin
                if (!req[m_id]) m_fin = 1;
                else begin m_len = int'(dur[m_id*DW +: DW]) * TD; m_age = 1; end
            end else if (m_age <= m_len) begin
                if (!req[m_id]) m_fin = 1;
                else m_age++;
            end else begin
                m_fin = 1;
            end
            if (m_fin) begin
                m_busy = 0;
`ifdef TIMER_ARB_PRIORITY_EN
                if (m_id != 0) m_ptr = (m_id + 1) % N;
`else
                m_ptr = (m_id + 1) % N;
`endif
            end
        end
    end

    // Compare every output against the model on every falling edge
    always @(negedge clock) begin
        logic [N-1:0] e_grant, e_done;
        logic e_out;
        e_grant = (m_busy != 0) ? N'(1 << m_id) : '0;
        e_out   = (m_busy != 0) && (m_age >= 1) && (m_age <= m_len);
        e_done  = ((m_busy != 0) && (m_age >= 1) && (m_age == m_len + 1)) ? N'(1 << m_id) : '0;
        check("model_grant", 32'(grant), 32'(e_grant));
        check("model_busy", 32'(busy), 32'(m_busy != 0));
        check("model_out", 32'(out), 32'(e_out));
        check("model_done", 32'(done), 32'(e_done));
        if (m_busy != 0) check("model_grant_id", 32'(grant_id), 32'(m_id));
    end

    // Activity monitor for the literal checks
    int out_cnt, done_cnt;
    logic [N-1:0] done_acc, prev_grant;
    logic [N-1:0] grant_log[$];
    always @(negedge clock) begin
        if (out) out_cnt++;
        if (done != '0) begin done_cnt++; done_acc |= done; end
        if (grant != '0 && grant != prev_grant) grant_log.push_back(grant);
        prev_grant = grant;
    end

    task automatic at_edge();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_stats();
        out_cnt = 0; done_cnt = 0; done_acc = '0; grant_log.delete();
    endtask

    task automatic do_reset();
        reset_l = 1'b0;
        req = '0;
        at_edge();
        at_edge();
        reset_l = 1'b1;
    endtask

    // Wait for done on requester id, then withdraw its request
    task automatic run_until_done(input int id, input int budget);
        bit seen;
        seen = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clock);
            #1;
            if (done[id]) begin
                req[id] = 1'b0;
                seen = 1;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    // Wait for the timer to go idle, then for the next grant
    task automatic wait_new_grant(input int budget);
        bit seen;
        seen = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clock); #1;
            if (grant == '0) seen = 1;
        end
        seen = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clock); #1;
            if (grant != '0) seen = 1;
        end
        if (!seen) check("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_out_cnt(input int n, input int budget);
        bit seen;
        seen = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clock); #1;
            if (out_cnt >= n) seen = 1;
        end
        if (!seen) check("out_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        reset_l = 1'b0;
        req = '0;
        dur = '0;
        prev_grant = '0;
        clear_stats();
        #23;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset_l = 1'b1;

        // Single requester, dur=3 -> 12 clocks of out
        at_edge();
        clear_stats();
        req = 4'b0010;
        dur = 16'h0030;
        at_edge();
        check("s1_grant_after_1_edge", 32'(grant), 32'b0010);
        run_until_done(1, 40);
        @(negedge clock); #1;
        check("s1_out_clocks", 32'(out_cnt), 32'd12);
        check("s1_done_strobes", 32'(done_cnt), 32'd1);
        check("s1_done_owner", 32'(done_acc), 32'b0010);
        check("s1_busy_after", 32'(busy), 32'd0);

        // Contention from a fresh pointer: grants 0,1,2,3
        do_reset();
        at_edge();
        clear_stats();
        req = 4'b1111;
        dur = 16'h1111;
        for (int i = 0; i < N; i++) run_until_done(i, 30);
        @(negedge clock); #1;
        check("s2_grant_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < N && i < grant_log.size(); i++)
            check("s2_grant_order", 32'(grant_log[i]), 32'(1 << i));
        check("s2_out_clocks", 32'(out_cnt), 32'd16);
        check("s2_done_strobes", 32'(done_cnt), 32'd4);

        // Zero duration: load then done, no pulse
        at_edge();
        clear_stats();
        req = 4'b0100;
        dur = 16'h0000;
        at_edge();
        at_edge();
        check("s3_done_two_cycles", 32'(done), 32'b0100);
        req = '0;
        at_edge();
        check("s3_out_never", 32'(out_cnt), 32'd0);
        check("s3_done_strobes", 32'(done_cnt), 32'd1);

        // Withdrawal of requester 0 on RUN cycle 7, requester 1 waiting
        do_reset();
        at_edge();
        clear_stats();
        req = 4'b0011;
        dur = 16'h0015;
        wait_out_cnt(7, 30);
        req[0] = 1'b0;
        @(negedge clock); #1;
        check("s4_out_dropped", 32'(out), 32'd0);
        check("s4_idle", 32'(busy), 32'd0);
        @(negedge clock); #1;
        check("s4_next_grant", 32'(grant), 32'b0010);
        run_until_done(1, 30);
        check("s4_no_done_0", 32'(done_acc[0]), 32'd0);
        check("s4_out_clocks", 32'(out_cnt), 32'd11);

        // Asynchronous reset mid-RUN
        at_edge();
        clear_stats();
        req = 4'b0100;
        dur = 16'h0900;
        wait_out_cnt(5, 30);
        #3;
        reset_l = 1'b0;
        #1;
        check("s5_rst_out", 32'(out), 32'd0);
        check("s5_rst_grant", 32'(grant), 32'd0);
        check("s5_rst_busy", 32'(busy), 32'd0);
        check("s5_rst_done", 32'(done), 32'd0);
        req = '0;
        repeat (2) @(negedge clock);
        #3;
        reset_l = 1'b1;
        at_edge();
        req = 4'b1010;
        dur = 16'h1111;
        at_edge();
        check("s5_ptr_zero_grant", 32'(grant), 32'b0010);
        req = 4'b0010;
        run_until_done(1, 30);
        check("s5_no_done_2", 32'(done_acc[2]), 32'd0);

        // Requester 0 arrives while 1 owns the timer
        do_reset();
        at_edge();
        clear_stats();
        req = 4'b0010;
        dur = 16'h1121;
        at_edge();
        check("s6_first_grant", 32'(grant), 32'b0010);
        wait_out_cnt(1, 20);
        req = 4'b0111;
        run_until_done(1, 30);
        wait_new_grant(30);
`ifdef TIMER_ARB_PRIORITY_EN
        check("s6_second_grant", 32'(grant), 32'b0001);
        run_until_done(0, 30);
        wait_new_grant(30);
        check("s6_third_grant", 32'(grant), 32'b0100);
        run_until_done(2, 30);
`else
        check("s6_second_grant", 32'(grant), 32'b0100);
        run_until_done(2, 30);
        wait_new_grant(30);
        check("s6_third_grant", 32'(grant), 32'b0001);
        run_until_done(0, 30);
`endif
        @(negedge clock); #1;
        check("s6_done_strobes", 32'(done_cnt), 32'd3);

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
